// File: rtl/disp_scan_ctl.sv
// Scan controller for an 8-digit common-anode 7-segment display with a
// double-buffered 32-bit hex value. Define LZ_BLANK_EN for leading-zero suppression.
module disp_scan_ctl #(
    parameter int DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        d_valid,
    input  logic [31:0] d_data,
    input  logic [7:0]  dp_n_in,
    output logic        d_ready,
    output logic [2:0]  dig_sel,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } pend_state_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] nibble_at(input logic [31:0] v, input logic [2:0] k);
        return v[{k, 2'b00} +: 4];
    endfunction

`ifdef LZ_BLANK_EN
    // Index of the most significant nonzero nibble; 0 when the value is 0 so digit 0 always shows.
    function automatic logic [2:0] msnz_index(input logic [31:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (v[4*i +: 4] != 4'h0) idx = 3'(i);
        end
        return idx;
    endfunction
`endif

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    dig_sel_q, dig_sel_d;
    logic          frame_tick_q, frame_tick_d;
    pend_state_e   state_q, state_d;
    logic [31:0]   pend_data_q, pend_data_d;
    logic [7:0]    pend_dp_q, pend_dp_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [7:0]    shadow_dp_q, shadow_dp_d;
    logic [6:0]    seg_n_q, seg_n_d;
    logic          dp_n_q, dp_n_d;

    logic          slot_tick;
    logic          wrap;
    logic [6:0]    seg_val;

    // Timebase: prescaler, digit index and frame pulse
    always_comb begin
        slot_tick    = (presc_q == PRE_MAX);
        wrap         = slot_tick && (dig_sel_q == 3'd7);
        presc_d      = slot_tick ? '0 : presc_q + PW'(1);
        dig_sel_d    = slot_tick ? dig_sel_q + 3'd1 : dig_sel_q;
        frame_tick_d = wrap;
    end

    // Pending/shadow handshake; shadow only ever changes on the wrap edge
    always_comb begin
        state_d     = state_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        d_ready     = 1'b0;
        case (state_q)
            EMPTY: begin
                d_ready = 1'b1;
                if (d_valid) begin
                    if (wrap) begin
                        shadow_d    = d_data;
                        shadow_dp_d = dp_n_in;
                    end else begin
                        pend_data_d = d_data;
                        pend_dp_d   = dp_n_in;
                        state_d     = FULL;
                    end
                end
            end
            FULL: begin
                if (wrap) begin
                    shadow_d    = pend_data_q;
                    shadow_dp_d = pend_dp_q;
                    state_d     = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Segment data is built from the post-edge digit and shadow so it never lags dig_sel
    always_comb begin
        seg_val = hex_to_seg(nibble_at(shadow_d, dig_sel_d));
`ifdef LZ_BLANK_EN
        if (dig_sel_d > msnz_index(shadow_d)) seg_val = 7'h7F;
`endif
        seg_n_d = en ? seg_val : 7'h7F;
        dp_n_d  = en ? shadow_dp_d[dig_sel_d] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            dig_sel_q    <= 3'd0;
            frame_tick_q <= 1'b0;
            state_q      <= EMPTY;
            shadow_q     <= 32'h0;
            shadow_dp_q  <= 8'hFF;
            seg_n_q      <= 7'h7F;
            dp_n_q       <= 1'b1;
        end else begin
            presc_q      <= presc_d;
            dig_sel_q    <= dig_sel_d;
            frame_tick_q <= frame_tick_d;
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
        end
    end

    // Pending payload is only meaningful while FULL, so it carries no reset
    always_ff @(posedge clk) begin
        pend_data_q <= pend_data_d;
        pend_dp_q   <= pend_dp_d;
    end

    assign dig_sel    = dig_sel_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_ctl.sv
// Directed self-checking bench for disp_scan_ctl with DIV=4 (32 clocks per frame).
module tb_disp_scan_ctl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        d_valid;
    logic [31:0] d_data;
    logic [7:0]  dp_n_in;
    logic        d_ready;
    logic [2:0]  dig_sel;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_tick;

    int n_tests;
    int n_fail;
    int c;
    int ft_count;

    // Zero digit above the top nonzero nibble: blanked with suppression, else "0"
`ifdef LZ_BLANK_EN
    localparam logic [6:0] ZHI = 7'h7F;
`else
    localparam logic [6:0] ZHI = 7'h40;
`endif

    disp_scan_ctl #(.DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .d_valid    (d_valid),
        .d_data     (d_data),
        .dp_n_in    (dp_n_in),
        .d_ready    (d_ready),
        .dig_sel    (dig_sel),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, c);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic run_to(input int target);
        while (c < target) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_seg"},   32'(seg_n),      32'h7F);
        chk({tag, "_dig"},   32'(dig_sel),    32'd0);
        chk({tag, "_rdy"},   32'(d_ready),    32'd1);
        chk({tag, "_dp"},    32'(dp_n),       32'd1);
        chk({tag, "_ftick"}, 32'(frame_tick), 32'd0);
    endtask

    logic [6:0] lz_exp [8];

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        c        = 0;
        ft_count = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        d_valid  = 1'b0;
        d_data   = 32'h0;
        dp_n_in  = 8'hFF;

        // Reset held across clock edges
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst_hold");
        rst_n = 1'b1;
        c = 0;
        chk_reset_vals("rst_rel");

        // First frame: digit stepping and a single frame pulse
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("scan_dig", 32'(dig_sel), 32'((c / 4) % 8));
            chk("scan_ftick", 32'(frame_tick), 32'(c == 32));
            if (frame_tick) ft_count++;
            if (c == 1) chk("scan_seg0", 32'(seg_n), 32'h40);
        end
        chk("ftick_count", 32'(ft_count), 32'd1);

        // A5 offered mid-frame, shown only from the next frame
        run_to(36);
        d_valid = 1'b1;
        d_data  = 32'h0000_00A5;
        dp_n_in = 8'hFE;
        tick();
        d_valid = 1'b0;
        chk("a5_rdy_full", 32'(d_ready), 32'd0);
        run_to(40);
        chk("a5_dig2_old", 32'(seg_n), 32'(ZHI));
        run_to(63);
        chk("a5_still_full", 32'(d_ready), 32'd0);
        tick();
        chk("a5_dig0_dig", 32'(dig_sel), 32'd0);
        chk("a5_dig0_seg", 32'(seg_n), 32'h12);
        chk("a5_dig0_dp", 32'(dp_n), 32'd0);
        chk("a5_rdy_empty", 32'(d_ready), 32'd1);
        run_to(68);
        chk("a5_dig1_seg", 32'(seg_n), 32'h08);
        chk("a5_dig1_dp", 32'(dp_n), 32'd1);
        run_to(72);
        chk("a5_dig2_seg", 32'(seg_n), 32'(ZHI));

        // Second offer while FULL is held off until the wrap
        run_to(65);
        d_valid = 1'b1;
        d_data  = 32'h0000_0012;
        dp_n_in = 8'hFF;
        run_to(73);
        chk("full_take12", 32'(d_ready), 32'd0);
        d_data  = 32'h0000_0003;
        run_to(92);
        chk("full_dig7_seg", 32'(seg_n), 32'(ZHI));
        run_to(95);
        chk("full_rdy_hold", 32'(d_ready), 32'd0);
        tick();
        chk("full_wrap_seg", 32'(seg_n), 32'h24);
        chk("full_wrap_rdy", 32'(d_ready), 32'd1);
        tick();
        chk("full_take3", 32'(d_ready), 32'd0);
        d_valid = 1'b0;
        run_to(100);
        chk("full_dig1_seg", 32'(seg_n), 32'h79);
        run_to(128);
        chk("held_dig0_seg", 32'(seg_n), 32'h30);
        chk("held_dig0_dp", 32'(dp_n), 32'd1);
        chk("held_rdy", 32'(d_ready), 32'd1);

        // Offer landing exactly on the wrap edge while EMPTY
        run_to(159);
        chk("wrapld_rdy_pre", 32'(d_ready), 32'd1);
        d_valid = 1'b1;
        d_data  = 32'h0000_0008;
        dp_n_in = 8'hFF;
        tick();
        d_valid = 1'b0;
        chk("wrapld_seg", 32'(seg_n), 32'h00);
        chk("wrapld_dig", 32'(dig_sel), 32'd0);
        chk("wrapld_ftick", 32'(frame_tick), 32'd1);
        chk("wrapld_rdy", 32'(d_ready), 32'd1);

        // Blank for a whole frame; scanning continues
        en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("blank_seg", 32'(seg_n), 32'h7F);
            chk("blank_dp", 32'(dp_n), 32'd1);
            chk("blank_dig", 32'(dig_sel), 32'((c / 4) % 8));
        end
        chk("blank_rdy", 32'(d_ready), 32'd1);
        en = 1'b1;
        tick();
        chk("unblank_seg", 32'(seg_n), 32'h00);

        // 0x120: leading zeros above digit 2
        run_to(194);
        d_valid = 1'b1;
        d_data  = 32'h0000_0120;
        dp_n_in = 8'hFF;
        tick();
        d_valid = 1'b0;
        chk("lz_rdy_full", 32'(d_ready), 32'd0);
        lz_exp[0] = 7'h40;
        lz_exp[1] = 7'h24;
        lz_exp[2] = 7'h79;
        for (int k = 3; k < 8; k++) lz_exp[k] = ZHI;
        for (int k = 0; k < 8; k++) begin
            run_to(224 + 4 * k);
            chk("lz_dig", 32'(dig_sel), 32'(k));
            chk("lz_seg", 32'(seg_n), 32'(lz_exp[k]));
        end

        // Reset mid-frame with a word pending
        run_to(236);
        d_valid = 1'b1;
        d_data  = 32'h0000_0777;
        tick();
        d_valid = 1'b0;
        chk("mid_rdy_full", 32'(d_ready), 32'd0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        @(posedge clk);
        #1;
        chk_reset_vals("mid_rst_hold");
        rst_n = 1'b1;
        c = 0;
        tick();
        chk("post_rst_seg", 32'(seg_n), 32'h40);
        chk("post_rst_dig", 32'(dig_sel), 32'd0);
        run_to(32);
        chk("post_rst_wrap_seg", 32'(seg_n), 32'h40);
        chk("post_rst_wrap_ftick", 32'(frame_tick), 32'd1);
        chk("post_rst_wrap_rdy", 32'(d_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
